// File: rtl/matriz_scan_if.sv
// Bundle of the scanner's enable/frame inputs and its row/column drive outputs.
// The master side feeds the image; the slave side is the scanner itself.
interface matriz_scan_if;
  logic        en;
  logic [34:0] frame;
  logic [6:0]  lin;
  logic [4:0]  col;
  logic [2:0]  idx;
  logic        frame_start;

  modport master (
    output en,
    output frame,
    input  lin,
    input  col,
    input  idx,
    input  frame_start
  );

  modport slave (
    input  en,
    input  frame,
    output lin,
    output col,
    output idx,
    output frame_start
  );
endinterface

// File: rtl/matriz_scan.sv
// Row scanner for the 7x5 LED matrix: walks rows 0..6 from a frame copy latched once per scan,
// spending DIV cycles per row with the first BLANK cycles of each row dark.
module matriz_scan #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic           clk,
  input  logic           rst,
  matriz_scan_if.slave   bus
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic          act_q, act_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [34:0]   shadow_q, shadow_d;
  logic          vis_s;

  // Next-state selection; shadow only reloads while idle, on scan start, or at the wrap edge.
  always_comb begin
    act_d    = act_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (!bus.en) begin
      act_d    = 1'b0;
      row_d    = 3'd0;
      cnt_d    = '0;
      shadow_d = bus.frame;
    end else if (!act_q) begin
      act_d    = 1'b1;
      row_d    = 3'd0;
      cnt_d    = '0;
      shadow_d = bus.frame;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end else if (row_q < 3'd6) begin
      cnt_d = '0;
      row_d = row_q + 3'd1;
    end else begin
      cnt_d    = '0;
      row_d    = 3'd0;
      shadow_d = bus.frame;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q    <= 1'b0;
      row_q    <= 3'd0;
      cnt_q    <= '0;
      shadow_q <= 35'd0;
    end else begin
      act_q    <= act_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // With no blanking the counter compare would be constant, so it is elaborated away.
  if (BLANK == 0) begin : g_noblank
    assign vis_s = act_q;
  end else begin : g_blank
    assign vis_s = act_q && (cnt_q >= BLANK_C);
  end

  // Output decode, driven purely from state so input glitches never reach the matrix.
  always_comb begin
    bus.lin = 7'd0;
    bus.col = 5'd0;
    if (vis_s) begin
      case (row_q)
        3'd0: begin bus.lin = 7'b0000001; bus.col = shadow_q[4:0];   end
        3'd1: begin bus.lin = 7'b0000010; bus.col = shadow_q[9:5];   end
        3'd2: begin bus.lin = 7'b0000100; bus.col = shadow_q[14:10]; end
        3'd3: begin bus.lin = 7'b0001000; bus.col = shadow_q[19:15]; end
        3'd4: begin bus.lin = 7'b0010000; bus.col = shadow_q[24:20]; end
        3'd5: begin bus.lin = 7'b0100000; bus.col = shadow_q[29:25]; end
        3'd6: begin bus.lin = 7'b1000000; bus.col = shadow_q[34:30]; end
        default: begin bus.lin = 7'd0; bus.col = 5'd0; end
      endcase
    end else begin
      bus.lin = 7'd0;
      bus.col = 5'd0;
    end
    bus.idx         = act_q ? row_q : 3'd0;
    bus.frame_start = act_q && (row_q == 3'd0) && (cnt_q == '0);
  end

endmodule

// File: doc/matriz_scan.md
# matriz_scan

Time-multiplexed row scanner for the 7-row × 5-column LED matrix. It is the read side of the row-addressing scheme. The switch decoder selects a single row from the 3-bit switch code. This block instead walks every row in turn from a latched 35-bit frame image. For each row it drives a one-hot row strobe, the 5 column bits and the encoded row index. A consistent frame is presented per scan, with a programmable blanking gap to suppress ghosting.

## Interface
- `DIV`, 4: clock cycles spent on each row. Legal range ≥ 2.
- `BLANK`, 1: cycles at the start of each row with strobes/columns forced off. Legal range 0..DIV-1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `en` in 1: scan enable, driven by the game's on/mode switches (ch7 & ch6).
- `frame` in 35: image. `frame[5*r+c]` is row r (0..6), column c (0..4), 1 = lit.
- `lin` out 7: one-hot row strobe, active-high, `lin[r]` for row r.
- `col` out 5: column data for the active row, active-high.
- `idx` out 3: encoded index of the current row (0..6).
- `frame_start` out 1: one-cycle pulse on the first cycle of row 0 of each scan.

## Operation
- **State registers:**
  - `act`: registered copy of `en`.
  - `row`: 3 bits, range 0..6.
  - `cnt`: counter, range 0..DIV-1.
  - `shadow`: 35-bit frame copy.
- **Outputs** are combinational from the state registers only (no path from `frame` or `en` inputs):
  - `vis = act && (cnt >= BLANK)`.
  - `lin = vis ? onehot(row) : 0`.
  - `col = vis ? shadow[5*row +: 5] : 0`.
  - `idx = act ? row : 0`.
  - `frame_start = act && row==0 && cnt==0`.
- **Per-edge update, priority order:**
  - `rst`: act=0, row=0, cnt=0, shadow=0.
  - else `en==0`: act=0, row=0, cnt=0, shadow<=frame (tracks the input continuously).
  - else `act==0` (first enabled edge): act=1, row=0, cnt=0, shadow<=frame.
  - else `cnt<DIV-1`: cnt++.
  - else `row<6`: cnt=0, row++.
  - else (wrap, row 6 at cnt DIV-1): cnt=0, row=0, shadow<=frame.
- **Frame update rule:** `shadow` never changes while act=1 except at the wrap edge. A `frame` change mid-scan is therefore not shown until the next scan.
- **Row 7 code:** the index 7 is never reached. `lin` has no bit 7.

## Timing
- **Reset values:** `lin`=0, `col`=0, `idx`=0, `frame_start`=0, all internal state 0.
- **Start of scan:** with `en` high at edge E0, `act`=1 after E0. `frame_start`=1 for the cycle after E0, with `idx`=0. Row 0 is lit from cycle BLANK after E0.
- **Row dwell:** DIV cycles, of which DIV-BLANK are lit. The first BLANK cycles of each row are dark.
- **Scan period:** 7·DIV cycles. `frame_start` repeats every 7·DIV cycles while `en` stays high.
- **`en` deassert:** at edge E1, all outputs are 0 from the cycle after E1. No partial-row completion.
- **Reset mid-scan:** all outputs are 0 the cycle after the reset edge. If `en` is held high, scan restarts at row 0 one edge after `rst` falls.
- **BLANK=0:** rows are lit on every cycle. The `lin` transition between rows is a direct one-hot change with no dark cycle.

## Test plan
- **Reset/idle:** rst=1 for 3 cycles with en=1 → `lin`=0, `col`=0, `idx`=0, `frame_start`=0 throughout. Release rst → one cycle later `frame_start`=1, `idx`=0, `lin`=0 (blank).
- **Full scan** (DIV=4, BLANK=1), frame = row r holds 5'b(r+1) pattern:
  - for each r: `lin`=1<<r and `col`=r+1 on cycles 1..3 of its dwell; 0 on cycle 0.
  - `idx` steps 0..6 every 4 cycles and wraps to 0 after 28 cycles.
  - `frame_start` pulses every 28 cycles.
- **Frame consistency:** change `frame` to all-ones while `idx`=3. Rows 3..6 of the current scan still show the old data. Row 0 of the next scan shows `col`=5'b11111.
- **Enable toggle:** drop `en` while `idx`=4 → next cycle all outputs 0. Raise `en` again → the scan restarts at `idx`=0 with a `frame_start` pulse and the current `frame` contents.
- **BLANK=0, DIV=2:** every cycle has exactly one bit of `lin` set. `col` equals the row data on every cycle. Scan period is 14 cycles.
- **Reset mid-row:** assert rst at `idx`=5, cnt=2 → next cycle outputs 0. After release with `en`=1, the first `frame_start` comes one edge later. `shadow` reloads from `frame`, with no stale data shown.
